mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined core.
- Runs a grant FSM with a registered memory request, a registered response and an ack timeout.
- Its per-port busy outputs feed the hazard logic, which uses them to stall IF/ID and to freeze EX/MEM.

Parameters:
- TIMEOUT, 16, max cycles in a busy state waiting for mem_ack before error abort (legal range 2..255).
- STARVE_LIMIT, 4, consecutive data grants allowed while i_req is pending (used only with the optional feature).

Ports:
- clk  in  1  clock, rising-edge.
- clr  in  1  reset, asynchronous, active-high.
- i_req  in  1  instruction fetch request; held high with i_addr stable until i_ready.
- i_addr  in  32  fetch address (PCF).
- i_rdata  out  32  fetched instruction (RD_instr).
- i_ready  out  1  one-cycle pulse: fetch done, i_rdata valid.
- i_busy  out  1  high while the fetch is pending or in service; drives StallF/StallD.
- d_req  in  1  data request; held high with d_we/d_addr/d_wdata stable until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address (ALUResultM).
- d_wdata  in  32  store data (WriteDataM).
- d_rdata  out  32  load data.
- d_ready  out  1  one-cycle pulse: data access done.
- d_busy  out  1  high while the data request is pending or in service; freezes the pipeline.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  32  memory address, registered.
- mem_wdata  out  32  memory write data, registered.
- mem_rdata  in  32  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, single-cycle pulse.
- err  out  1  one-cycle pulse: timeout abort.

Behaviour:
- Reset value of every output is 0. Reset forces state IDLE and clears both counters.
- FSM states:
  - IDLE: if d_req, latch the data request and go to D_BUSY; else if i_req, latch the fetch and go to I_BUSY; else stay in IDLE.
  - I_BUSY / D_BUSY: mem_req=1 with the latched mem_we/mem_addr/mem_wdata. Fetches always drive mem_we=0.
    - On mem_ack: capture mem_rdata into the port's rdata register, go to I_DONE / D_DONE.
    - If the timeout counter reaches TIMEOUT with no ack: rdata=0, go to the DONE state with err asserted there.
  - I_DONE / D_DONE: port ready=1 for exactly one cycle, mem_req=0, then go to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0; mem_req high cycles 1..k; ack at cycle k; ready at cycle k+1.
  - Minimum round trip (ack on cycle 1) is 3 cycles, request to next IDLE.
- Requester handshake: the requester drops req (or presents a new request) in the cycle after ready. A req still high in IDLE is treated as a new transaction.
- Priority: data beats fetch whenever both are requesting in IDLE. There is no preemption; a request arriving during the other port's busy state waits.
- Read data: i_rdata/d_rdata hold their last captured value until the next completion on that port. Stores leave d_rdata unchanged.
- Busy outputs: i_busy = i_req & ~i_ready; d_busy = d_req & ~d_ready.
- Ignored inputs: mem_ack is ignored outside the busy states. An ack arriving on the timeout cycle counts as completion (no err).
- Timeout counter: 8-bit, cleared on entry to a busy state, saturating.
- Reset mid-transaction: mem_req drops asynchronously, no ready is pulsed, and the memory side is responsible for discarding the access.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - A 3-bit+ counter counts consecutive data grants made while i_req=1. It clears on any fetch grant, or on a data grant made while i_req=0.
  - When the count equals STARVE_LIMIT and both ports are requesting in IDLE, the fetch is granted.
- Undefined: strict data priority, no counter logic.

Test Plan:
- clr pulse mid-D_BUSY (mem_req=1) -> mem_req=0 immediately, asynchronously; all outputs 0; state IDLE; no d_ready.
- i_req, i_addr=0x0000_0010, memory acks after 2 cycles with 0x0051_0093 -> mem_addr=0x10, mem_we=0 in cycles 1-2, i_ready at cycle 3, i_rdata=0x0051_0093.
- i_req and d_req rise together, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, ack after 1 cycle each:
  - data served first (mem_we=1, mem_wdata=0xDEADBEEF);
  - d_ready at cycle 2, then fetch granted from IDLE at cycle 3;
  - i_busy high throughout until i_ready.
- d_req with mem_ack never asserted, TIMEOUT=16 -> err and d_ready pulse together after 16 busy cycles, d_rdata=0, FSM returns to IDLE.
- Ack arriving while IDLE -> ignored, no ready pulse. Ack on the exact timeout cycle -> normal completion, err=0.
- With ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, d_req and i_req held high continuously -> grant order D,D,D,D,I,D,... Without the macro -> only D grants.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (i_*) and load/store (d_*).
// Define ARB_STARVE_GUARD_EN to let a waiting fetch through after STARVE_LIMIT back-to-back data grants.
module mem_port_arbiter #(
  parameter int TIMEOUT      = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  output logic        i_busy,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] tmo_cnt;
  logic       grant_d;

  // Busy is gated by clr so every output reads 0 while reset is held.
  assign i_busy = i_req & ~i_ready & ~clr;
  assign d_busy = d_req & ~d_ready & ~clr;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;

  assign grant_d = d_req & ~(i_req & (starve_cnt == STARVE_MAX));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_d) begin
        if (!i_req)
          starve_cnt <= '0;
        else if (starve_cnt != STARVE_MAX)
          starve_cnt <= starve_cnt + 1'b1;
      end else if (i_req) begin
        starve_cnt <= '0;
      end
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT == 0);
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      i_rdata   <= '0;
      i_ready   <= 1'b0;
      d_rdata   <= '0;
      d_ready   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (grant_d) begin
            state     <= D_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (i_req) begin
            state     <= I_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
          end
        end
        I_BUSY, D_BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (state == I_BUSY) begin
              i_rdata <= mem_rdata;
              i_ready <= 1'b1;
              state   <= I_DONE;
            end else begin
              if (!mem_we)
                d_rdata <= mem_rdata;
              d_ready <= 1'b1;
              state   <= D_DONE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            // Abort: complete the port with zero data and flag the error alongside ready.
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= 1'b1;
            if (state == I_BUSY) begin
              i_rdata <= '0;
              i_ready <= 1'b1;
              state   <= I_DONE;
            end else begin
              d_rdata <= '0;
              d_ready <= 1'b1;
              state   <= D_DONE;
            end
          end else if (tmo_cnt != 8'hFF) begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        I_DONE, D_DONE: state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default TIMEOUT=16, STARVE_LIMIT=4).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ready, i_busy;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready, d_busy;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        err;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.TIMEOUT(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .clr(clr),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_busy(i_busy),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_busy(d_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({i_rdata, i_ready, i_busy, d_rdata, d_ready, d_busy, mem_req, mem_we, mem_addr, mem_wdata, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b addr=%h ready=%b/%b want all 0", mem_req, mem_addr, i_ready, d_ready);
    end
    @(negedge clk);
    clr = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 32'h0000_0010;
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr, i_busy} !== {1'b1, 1'b0, 32'h10, 1'b1}) begin
      failures++;
      $display("FAIL fetch_cycle1 got req=%b we=%b addr=%h busy=%b want 1 0 00000010 1", mem_req, mem_we, mem_addr, i_busy);
    end
    tick();
    checks++;
    if ({mem_req, mem_we, i_ready} !== 3'b100) begin
      failures++;
      $display("FAIL fetch_cycle2 got req=%b we=%b ready=%b want 1 0 0", mem_req, mem_we, i_ready);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0051_0093;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    checks++;
    if ({i_ready, i_rdata, mem_req, err, i_busy} !== {1'b1, 32'h0051_0093, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL fetch_ready got ready=%b rdata=%h req=%b err=%b busy=%b want 1 00510093 0 0 0", i_ready, i_rdata, mem_req, err, i_busy);
    end
    i_req = 1'b0;
    tick();
    checks++;
    if ({i_ready, mem_req, i_rdata} !== {1'b0, 1'b0, 32'h0051_0093}) begin
      failures++;
      $display("FAIL fetch_after got ready=%b req=%b rdata=%h want 0 0 00510093", i_ready, mem_req, i_rdata);
    end
    $display("test_fetch done");
  endtask

  task automatic test_priority();
    i_req = 1'b1; i_addr = 32'h0000_0020;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, i_busy, d_busy} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL prio_data_first got req=%b we=%b addr=%h wdata=%h ib=%b db=%b want 1 1 00000100 deadbeef 1 1",
               mem_req, mem_we, mem_addr, mem_wdata, i_busy, d_busy);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    checks++;
    if ({d_ready, i_ready, i_busy, mem_req, d_rdata} !== {1'b1, 1'b0, 1'b1, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL prio_store_done got dr=%b ir=%b ib=%b req=%b drdata=%h want 1 0 1 0 00000000", d_ready, i_ready, i_busy, mem_req, d_rdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick();
    checks++;
    if ({mem_req, i_busy} !== 2'b01) begin
      failures++;
      $display("FAIL prio_idle_gap got req=%b ib=%b want 0 1", mem_req, i_busy);
    end
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr, i_busy} !== {1'b1, 1'b0, 32'h20, 1'b1}) begin
      failures++;
      $display("FAIL prio_fetch_grant got req=%b we=%b addr=%h ib=%b want 1 0 00000020 1", mem_req, mem_we, mem_addr, i_busy);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    checks++;
    if ({i_ready, i_rdata, i_busy} !== {1'b1, 32'h1234_5678, 1'b0}) begin
      failures++;
      $display("FAIL prio_fetch_done got ready=%b rdata=%h ib=%b want 1 12345678 0", i_ready, i_rdata, i_busy);
    end
    i_req = 1'b0;
    tick();
    $display("test_priority done");
  endtask

  task automatic test_timeout();
    bit ok;
    int bad_cycle;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    checks++;
    if ({d_ready, d_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      failures++;
      $display("FAIL load_done got ready=%b rdata=%h want 1 cafef00d", d_ready, d_rdata);
    end
    d_req = 1'b0;
    tick();
    d_req = 1'b1; d_addr = 32'h0000_0204;
    ok = 1'b1; bad_cycle = 0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (ok && (mem_req !== 1'b1 || d_ready !== 1'b0 || err !== 1'b0)) begin
        ok = 1'b0; bad_cycle = n;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL timeout_window got early change at busy cycle %0d want req=1 ready=0 err=0 for 16 cycles", bad_cycle);
    end
    tick();
    checks++;
    if ({err, d_ready, d_rdata, mem_req} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL timeout_abort got err=%b ready=%b rdata=%h req=%b want 1 1 00000000 0", err, d_ready, d_rdata, mem_req);
    end
    d_req = 1'b0;
    tick();
    checks++;
    if ({err, d_ready, mem_req} !== 3'b000) begin
      failures++;
      $display("FAIL timeout_idle got err=%b ready=%b req=%b want 0 0 0", err, d_ready, mem_req);
    end
    $display("test_timeout done");
  endtask

  task automatic test_ack_edges();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    checks++;
    if ({i_ready, d_ready, mem_req, err, i_rdata, d_rdata} !== {4'b0000, 32'h1234_5678, 32'h0}) begin
      failures++;
      $display("FAIL idle_ack got ir=%b dr=%b req=%b err=%b irdata=%h drdata=%h want 0 0 0 0 12345678 00000000",
               i_ready, d_ready, mem_req, err, i_rdata, d_rdata);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0208;
    for (int n = 1; n <= 16; n++) tick();
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    checks++;
    if ({d_ready, err, d_rdata} !== {1'b1, 1'b0, 32'hA5A5_5A5A}) begin
      failures++;
      $display("FAIL ack_on_timeout got ready=%b err=%b rdata=%h want 1 0 a5a55a5a", d_ready, err, d_rdata);
    end
    d_req = 1'b0;
    tick();
    $display("test_ack_edges done");
  endtask

  task automatic test_reset_mid();
    bit saw_ready;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0300; d_wdata = 32'h5555_AAAA;
    tick();
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_busy got req=%b want 1", mem_req);
    end
    #2 clr = 1'b1;
    #1;
    checks++;
    if ({i_rdata, i_ready, i_busy, d_rdata, d_ready, d_busy, mem_req, mem_we, mem_addr, mem_wdata, err} !== '0) begin
      failures++;
      $display("FAIL rstmid_async got req=%b we=%b addr=%h db=%b drdata=%h want all 0", mem_req, mem_we, mem_addr, d_busy, d_rdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    saw_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (d_ready !== 1'b0 || mem_req !== 1'b0) saw_ready = 1'b1;
    end
    checks++;
    if (saw_ready) begin
      failures++;
      $display("FAIL rstmid_no_ready got activity after reset want ready=0 req=0");
    end
    i_req = 1'b1; i_addr = 32'h0000_0044;
    tick();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h44}) begin
      failures++;
      $display("FAIL rstmid_idle got req=%b addr=%h want 1 00000044", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0;
    tick();
    mem_ack = 1'b0;
    i_req = 1'b0;
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    logic exp_data [6];
    bit   got_data;
    int   wait_n;
`ifdef ARB_STARVE_GUARD_EN
    exp_data = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    exp_data = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    i_req = 1'b1; i_addr = 32'h0000_0040;
    for (int g = 0; g < 6; g++) begin
      wait_n = 0;
      tick();
      while (mem_req !== 1'b1 && wait_n < 4) begin
        tick();
        wait_n++;
      end
      got_data = (mem_addr == 32'h300);
      checks++;
      if (mem_req !== 1'b1 || got_data !== exp_data[g]) begin
        failures++;
        $display("FAIL b2b_grant%0d got req=%b data=%b want req=1 data=%b", g, mem_req, got_data, exp_data[g]);
      end
      mem_ack = 1'b1; mem_rdata = 32'h100 + 32'(g);
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({d_ready, i_ready} !== {exp_data[g], ~exp_data[g]}) begin
        failures++;
        $display("FAIL b2b_ready%0d got d=%b i=%b want d=%b i=%b", g, d_ready, i_ready, exp_data[g], ~exp_data[g]);
      end
      $display("grant %0d data=%b", g, got_data);
    end
    d_req = 1'b0; i_req = 1'b0;
    tick();
    tick();
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_timeout();
    test_ack_edges();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
